// File: rtl/pc_fetch_unit_if.sv
// Handshake bundle between the fetch unit, the PC-source mux, instruction
// memory and decode. The master modport is the fetch unit's view; the slave
// modport is the view of the surrounding pipeline and memory.
interface pc_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            id_ready;
  logic [31:0]     fetch_count;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_valid, if_pc, if_instr,
    input  id_ready,
    output fetch_count
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_valid, if_pc, if_instr,
    output id_ready,
    input  fetch_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the program counter, issues one outstanding
// instruction-memory request at a time and holds the fetched instruction for
// decode until it is consumed. A redirect flushes the held instruction; if a
// request for the old PC is still in flight, its response is discarded in
// DRAIN before fetching resumes from the new PC.
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_fetch_unit_if.master   bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] if_pc_q;
  logic [31:0]     if_instr_q;
  logic            if_valid_q;
  logic [31:0]     fetch_count_q;
  logic [XLEN-1:0] redirect_aligned;

  assign redirect_aligned   = {bus.redirect_pc[XLEN-1:2], 2'b00};

  assign bus.imem_req_valid = (state_q == FETCH);
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instr       = if_instr_q;
  assign bus.fetch_count    = fetch_count_q;

  // Fetch FSM with registered decode-side outputs; a redirect overrides every
  // other event in the cycle and chooses between FETCH and DRAIN depending on
  // whether an old-PC response is still owed by memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      if_pc_q       <= '0;
      if_instr_q    <= '0;
      if_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else if (bus.redirect_valid) begin
      pc_q       <= redirect_aligned;
      if_valid_q <= 1'b0;
      case (state_q)
        FETCH:   state_q <= bus.imem_req_ready ? DRAIN : FETCH;
        WAIT:    state_q <= bus.imem_rsp_valid ? FETCH : DRAIN;
        FULL:    state_q <= FETCH;
        DRAIN:   state_q <= bus.imem_rsp_valid ? FETCH : DRAIN;
        default: state_q <= FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.imem_req_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            if_instr_q <= bus.imem_rsp_data;
            if_pc_q    <= pc_q;
            if_valid_q <= 1'b1;
            pc_q       <= pc_q + XLEN'(4);
            state_q    <= FULL;
          end
        end
        FULL: begin
          if (bus.id_ready) begin
            if_valid_q    <= 1'b0;
            fetch_count_q <= fetch_count_q + 32'd1;
            state_q       <= FETCH;
          end
        end
        DRAIN: begin
          if (bus.imem_rsp_valid) state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit: sequential fetch, decode stall,
// redirects in every interesting state, PC wrap-around and async reset.
module tb_pc_fetch_unit;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  pc_fetch_unit_if #(.XLEN(32)) bus ();

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction word the bench's memory returns for a given address
  function automatic logic [31:0] instrFor(input logic [31:0] addr);
    return addr ^ 32'h1357_9BDF;
  endfunction

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.id_ready       = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst_n = 1'b0;
    #3;
    vectors++; if (bus.if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_if_valid got %b want 0", bus.if_valid); end
    vectors++; if (bus.if_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_if_pc got %h want 0", bus.if_pc); end
    vectors++; if (bus.if_instr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_if_instr got %h want 0", bus.if_instr); end
    vectors++; if (bus.fetch_count !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_fetch_count got %0d want 0", bus.fetch_count); end
    #10;
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.imem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_req_valid got %b want 1", bus.imem_req_valid); end
    vectors++; if (bus.imem_req_addr !== 32'h100) begin miscompares++; $display("[TB] FAIL reset_req_addr got %h want 00000100", bus.imem_req_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 32'h100 + 32'(4 * i);
      vectors++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== a) begin miscompares++; $display("[TB] FAIL seq_req valid=%b addr=%h want 1/%h", bus.imem_req_valid, bus.imem_req_addr, a); end
      bus.imem_req_ready = 1'b1;
      bus.id_ready       = 1'b1;
      tick();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = instrFor(a);
      tick();
      bus.imem_rsp_valid = 1'b0;
      vectors++; if (bus.if_valid !== 1'b1 || bus.if_pc !== a || bus.if_instr !== instrFor(a)) begin miscompares++; $display("[TB] FAIL seq_out valid=%b pc=%h instr=%h want 1/%h/%h", bus.if_valid, bus.if_pc, bus.if_instr, a, instrFor(a)); end
      tick();
      vectors++; if (bus.fetch_count !== 32'(i + 1)) begin miscompares++; $display("[TB] FAIL seq_count got %0d want %0d", bus.fetch_count, i + 1); end
    end
    idleInputs();
  endtask

  task automatic test_stall();
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = instrFor(32'h10C);
    tick();
    bus.imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h10C || bus.if_instr !== instrFor(32'h10C)) begin miscompares++; $display("[TB] FAIL stall_hold valid=%b pc=%h instr=%h", bus.if_valid, bus.if_pc, bus.if_instr); end
      vectors++; if (bus.imem_req_valid !== 1'b0 || bus.fetch_count !== 32'd3) begin miscompares++; $display("[TB] FAIL stall_req_count req=%b count=%0d want 0/3", bus.imem_req_valid, bus.fetch_count); end
    end
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
    vectors++; if (bus.fetch_count !== 32'd4 || bus.if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_release count=%0d valid=%b want 4/0", bus.fetch_count, bus.if_valid); end
    vectors++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h110) begin miscompares++; $display("[TB] FAIL stall_next_req valid=%b addr=%h want 1/00000110", bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h2002;
    tick();
    bus.redirect_valid = 1'b0;
    vectors++; if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== 32'h2000) begin miscompares++; $display("[TB] FAIL rdw_drain req=%b addr=%h want 0/00002000", bus.imem_req_valid, bus.imem_req_addr); end
    tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rsp_valid = 1'b0;
    vectors++; if (bus.if_valid !== 1'b0 || bus.if_instr !== instrFor(32'h10C)) begin miscompares++; $display("[TB] FAIL rdw_stale valid=%b instr=%h want 0/%h", bus.if_valid, bus.if_instr, instrFor(32'h10C)); end
    vectors++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h2000) begin miscompares++; $display("[TB] FAIL rdw_next_req valid=%b addr=%h want 1/00002000", bus.imem_req_valid, bus.imem_req_addr); end
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = instrFor(32'h2000);
    tick();
    bus.imem_rsp_valid = 1'b0;
    vectors++; if (bus.if_pc !== 32'h2000 || bus.if_instr !== instrFor(32'h2000)) begin miscompares++; $display("[TB] FAIL rdw_target pc=%h instr=%h want 00002000/%h", bus.if_pc, bus.if_instr, instrFor(32'h2000)); end
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
    vectors++; if (bus.fetch_count !== 32'd5) begin miscompares++; $display("[TB] FAIL rdw_count got %0d want 5", bus.fetch_count); end
  endtask

  task automatic test_redirect_same_cycle();
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h3000;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = instrFor(32'h2004);
    tick();
    idleInputs();
    vectors++; if (bus.if_valid !== 1'b0 || bus.fetch_count !== 32'd5) begin miscompares++; $display("[TB] FAIL rsc_rsp valid=%b count=%0d want 0/5", bus.if_valid, bus.fetch_count); end
    vectors++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h3000) begin miscompares++; $display("[TB] FAIL rsc_rsp_req valid=%b addr=%h want 1/00003000", bus.imem_req_valid, bus.imem_req_addr); end
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = instrFor(32'h3000);
    tick();
    bus.imem_rsp_valid = 1'b0;
    vectors++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h3000) begin miscompares++; $display("[TB] FAIL rsc_full valid=%b pc=%h want 1/00003000", bus.if_valid, bus.if_pc); end
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h4000;
    tick();
    idleInputs();
    vectors++; if (bus.if_valid !== 1'b0 || bus.fetch_count !== 32'd5) begin miscompares++; $display("[TB] FAIL rsc_consume valid=%b count=%0d want 0/5", bus.if_valid, bus.fetch_count); end
    vectors++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h4000) begin miscompares++; $display("[TB] FAIL rsc_consume_req valid=%b addr=%h want 1/00004000", bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    vectors++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL wrap_req valid=%b addr=%h want 1/fffffffc", bus.imem_req_valid, bus.imem_req_addr); end
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = instrFor(32'hFFFF_FFFC);
    tick();
    bus.imem_rsp_valid = 1'b0;
    vectors++; if (bus.if_pc !== 32'hFFFF_FFFC || bus.if_instr !== instrFor(32'hFFFF_FFFC)) begin miscompares++; $display("[TB] FAIL wrap_out pc=%h instr=%h", bus.if_pc, bus.if_instr); end
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
    vectors++; if (bus.imem_req_addr !== 32'h0 || bus.fetch_count !== 32'd6) begin miscompares++; $display("[TB] FAIL wrap_next addr=%h count=%0d want 00000000/6", bus.imem_req_addr, bus.fetch_count); end
  endtask

  task automatic test_async_reset();
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    vectors++; if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_in_wait req=%b want 0", bus.imem_req_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0 || bus.fetch_count !== 32'h0) begin miscompares++; $display("[TB] FAIL arst_outputs valid=%b pc=%h instr=%h count=%0d want all zero", bus.if_valid, bus.if_pc, bus.if_instr, bus.fetch_count); end
    vectors++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin miscompares++; $display("[TB] FAIL arst_req valid=%b addr=%h want 1/00000100", bus.imem_req_valid, bus.imem_req_addr); end
    #2;
    rst_n = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD0_BAD0;
    tick();
    bus.imem_rsp_valid = 1'b0;
    vectors++; if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin miscompares++; $display("[TB] FAIL arst_stray valid=%b req=%b addr=%h want 0/1/00000100", bus.if_valid, bus.imem_req_valid, bus.imem_req_addr); end
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = instrFor(32'h100);
    tick();
    bus.imem_rsp_valid = 1'b0;
    vectors++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.if_instr !== instrFor(32'h100)) begin miscompares++; $display("[TB] FAIL arst_refetch valid=%b pc=%h instr=%h", bus.if_valid, bus.if_pc, bus.if_instr); end
  endtask

  // Run every scenario in order, then report
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
